// File: rtl/rotator_pkg.sv
// Shared definitions for the rotator datapath: single-bit rotate helpers,
// the aligner FSM state type and the rotate-direction encoding.
package rotator_pkg;

    // Widest word the rotate helpers handle; callers zero-extend into this.
    localparam int ROT_MAX_W = 64;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } aligner_state_t;

    // Rotate the low w bits of v left by one; bits at and above w come back as 0.
    function automatic logic [ROT_MAX_W-1:0] rol1(input logic [ROT_MAX_W-1:0] v,
                                                  input int unsigned w);
        logic [ROT_MAX_W-1:0] mask;
        logic [ROT_MAX_W-1:0] vm;
        mask = (64'd1 << w) - 64'd1;
        vm   = v & mask;
        return ((vm << 1) | (vm >> (w - 1))) & mask;
    endfunction

    // Rotate the low w bits of v right by one; bits at and above w come back as 0.
    function automatic logic [ROT_MAX_W-1:0] ror1(input logic [ROT_MAX_W-1:0] v,
                                                  input int unsigned w);
        logic [ROT_MAX_W-1:0] mask;
        logic [ROT_MAX_W-1:0] vm;
        mask = (64'd1 << w) - 64'd1;
        vm   = v & mask;
        return ((vm >> 1) | (vm << (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/rotatorunit.sv
// Loadable rotate register: loads a word, then rotates it by one bit per
// enabled cycle in the requested direction.
module rotatorunit
    import rotator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic             dir,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0]     word_r;
    logic [WIDTH-1:0]     next_s;
    logic [ROT_MAX_W-1:0] wide_s;
    logic [ROT_MAX_W-1:0] rotl_s;
    logic [ROT_MAX_W-1:0] rotr_s;

    // Next rotated value of the held word in the selected direction.
    always_comb begin
        wide_s = ROT_MAX_W'(word_r);
        rotl_s = rol1(wide_s, WIDTH);
        rotr_s = ror1(wide_s, WIDTH);
        if (dir == DIR_RIGHT) begin
            next_s = rotr_s[WIDTH-1:0];
        end else begin
            next_s = rotl_s[WIDTH-1:0];
        end
    end

    // Word register: load wins over rotate; nothing moves without enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= '0;
        end else if (enable) begin
            if (load) begin
                word_r <= data_in;
            end else begin
                word_r <= next_s;
            end
        end else begin
            word_r <= word_r;
        end
    end

    assign data_out = word_r;

endmodule

// File: rtl/rotation_aligner.sv
// Recovers the rotation applied to a word: rotates the accepted word back one
// bit per enabled cycle until it equals the programmed pattern, then reports
// the realigned word, the number of rotations and whether a match was found.
module rotation_aligner
    import rotator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic [WIDTH-1:0] pattern,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aligned_out,
    output logic [AW-1:0]    amount_out,
    output logic             found_out
);

    aligner_state_t   state_r;
    aligner_state_t   state_next_s;
    logic [AW-1:0]    count_r;
    logic             dir_r;
    logic [WIDTH-1:0] orig_r;
    logic [WIDTH-1:0] work_s;
    logic [WIDTH-1:0] aligned_r;
    logic [AW-1:0]    amount_r;
    logic             found_r;
    logic             accept_s;
    logic             step_s;
    logic             hit_s;
    logic             miss_s;
    logic             match_s;
    logic             last_s;
    logic             unit_en_s;

    assign match_s   = (work_s == pattern);
    assign last_s    = (count_r == AW'(WIDTH - 1));
    assign unit_en_s = accept_s | step_s;

    rotatorunit #(
        .WIDTH (WIDTH)
    ) u_work (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_s),
        .enable   (unit_en_s),
        .dir      (dir_r),
        .data_in  (data_in),
        .data_out (work_s)
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        hit_s        = 1'b0;
        miss_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = SEARCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEARCH: begin
                if (!enable) begin
                    state_next_s = SEARCH;
                end else if (match_s) begin
                    hit_s        = 1'b1;
                    state_next_s = DONE;
                end else if (last_s) begin
                    miss_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    step_s       = 1'b1;
                    state_next_s = SEARCH;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture and rotation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            dir_r   <= DIR_LEFT;
            orig_r  <= '0;
        end else if (accept_s) begin
            count_r <= '0;
            dir_r   <= dir;
            orig_r  <= data_in;
        end else if (step_s) begin
            count_r <= count_r + AW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    // Result registers, written once when the search resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aligned_r <= '0;
            amount_r  <= '0;
            found_r   <= 1'b0;
        end else if (hit_s) begin
            aligned_r <= work_s;
            amount_r  <= count_r;
            found_r   <= 1'b1;
        end else if (miss_s) begin
            aligned_r <= orig_r;
            amount_r  <= '0;
            found_r   <= 1'b0;
        end else begin
            aligned_r <= aligned_r;
        end
    end

    assign in_ready    = (state_r == IDLE);
    assign out_valid   = (state_r == DONE);
    assign aligned_out = aligned_r;
    assign amount_out  = amount_r;
    assign found_out   = found_r;

endmodule

// File: tb/tb_rotation_aligner.sv
// Self-checking bench for rotation_aligner against a rotate-by-k search model.
module tb_rotation_aligner;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic         dir;
    logic [W-1:0] pattern;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] aligned_out;
    logic [2:0]   amount_out;
    logic         found_out;

    int checks_cnt;
    int errors_cnt;

    rotation_aligner #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .dir         (dir),
        .pattern     (pattern),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aligned_out (aligned_out),
        .amount_out  (amount_out),
        .found_out   (found_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Try every rotation amount k in ascending order; first hit wins.
    function automatic void ref_align(input int d, input int p, input int dr,
                                      output int fnd, output int amt, output int al);
        int r;
        fnd = 0; amt = 0; al = d;
        for (int k = 0; k < W; k++) begin
            if (dr == 1) r = ((d >> k) | (d << (W - k))) & 255;
            else         r = ((d << k) | (d >> (W - k))) & 255;
            if (r == p && fnd == 0) begin
                fnd = 1; amt = k; al = r;
            end
        end
    endfunction

    // One request from accept to consumption; called at a negedge while IDLE.
    task automatic run_req(input logic [7:0] d, input logic dr, input logic [7:0] p,
                           input int stall_at, input int stall_len, input bit rnd_en,
                           input int hold_cycles);
        int ef, ea, eal, lat, stalls, exp_lat;
        bit done;
        ref_align(int'(d), int'(p), int'(dr), ef, ea, eal);
        check_val("pre_in_ready", in_ready, 1);
        data_in = d; dir = dr; pattern = p; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        lat = 0; stalls = 0; done = 1'b0;
        while (!done && lat < 64) begin
            if (rnd_en) enable = ($urandom_range(0, 3) != 0);
            else        enable = !(lat >= stall_at && lat < stall_at + stall_len);
            if (!enable) stalls++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) done = 1'b1;
        end
        enable = 1'b1;
        check_val("completed", done, 1);
        exp_lat = ((ef != 0) ? ea + 1 : W) + stalls;
        check_val("latency", lat, exp_lat);
        check_val("found", found_out, ef);
        check_val("amount", amount_out, ea);
        check_val("aligned", aligned_out, eal);
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid = 1'b1;
            data_in  = 8'hFF;
            @(posedge clk);
            @(negedge clk);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_in_ready", in_ready, 0);
            check_val("hold_aligned", aligned_out, eal);
            check_val("hold_amount", amount_out, ea);
            check_val("hold_found", found_out, ef);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_out_valid", out_valid, 0);
        check_val("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int pat;
        checks_cnt = 0; errors_cnt = 0;
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; data_in = 8'h00;
        dir = 1'b0; pattern = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_aligned", aligned_out, 0);
        check_val("rst_amount", amount_out, 0);
        check_val("rst_found", found_out, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("idle_in_ready", in_ready, 1);
            check_val("idle_out_valid", out_valid, 0);
        end

        // Directed cases
        run_req(8'h48, 1'b1, 8'h12, 0, 0, 1'b0, 0);
        check_val("dir_r_amount2", amount_out, 2);
        run_req(8'h09, 1'b0, 8'h12, 0, 0, 1'b0, 0);
        check_val("dir_l_amount1", amount_out, 1);
        run_req(8'h12, 1'b0, 8'h12, 0, 0, 1'b0, 0);
        run_req(8'h13, 1'b0, 8'h12, 0, 0, 1'b0, 0);
        check_val("miss_aligned", aligned_out, 8'h13);
        run_req(8'h55, 1'b0, 8'hAA, 0, 0, 1'b0, 0);
        run_req(8'h01, 1'b1, 8'h80, 1, 4, 1'b0, 5);

        // Reset in the middle of a search
        pattern = 8'h01; data_in = 8'h80; dir = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("mid_search_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", in_ready, 1);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_aligned", aligned_out, 0);
        check_val("abort_amount", amount_out, 0);
        check_val("abort_found", found_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(8'h80, 1'b0, 8'h01, 0, 0, 1'b0, 0);

        // Full sweep with pattern 0xA5, both directions
        for (int dv = 0; dv < 2; dv++) begin
            for (int d = 0; d < 256; d++) begin
                run_req(8'(d), dv[0], 8'hA5, 0, 0, 1'b0, 0);
            end
        end

        // Random words, patterns and enable gaps
        for (int n = 0; n < 60; n++) begin
            pat = $urandom_range(0, 255);
            if (n % 2 == 0) begin
                // Make the pattern a rotation of the data half the time.
                run_req(8'(((pat << (n % 8)) | (pat >> (8 - (n % 8)))) & 255),
                        1'($urandom), 8'(pat), 0, 0, 1'b1, $urandom_range(0, 2));
            end else begin
                run_req(8'($urandom), 1'($urandom), 8'(pat), 0, 0, 1'b1, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule

// File: doc/rotation_aligner.md
# rotation_aligner

Recovers the rotation applied to a word by a rotate register. It accepts a rotated word over a valid/ready handshake and rotates it back by one bit per cycle until it matches a programmed pattern. It then returns the realigned word, the rotation count and a found flag. The block sits on the consumer side of the rotator datapath, for lane and word-alignment recovery.

## Interface
- WIDTH, 8, word width in bits; WIDTH >= 2.
- AW, $clog2(WIDTH), width of the rotation-count output.

- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- enable  input  1  search gate; 0 freezes the SEARCH state (no rotate, no count, no compare-exit).
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- data_in  input  WIDTH  rotated word, captured on accept.
- dir  input  1  search rotate direction, captured on accept; 0 = rotate-left, 1 = rotate-right.
- pattern  input  WIDTH  target word; sampled every SEARCH cycle and must be held stable while a search is in progress.
- out_valid  output  1  result valid; high in DONE.
- out_ready  input  1  result accepted.
- aligned_out  output  WIDTH  realigned word (or the original word if no match was found).
- amount_out  output  AW  number of single-bit rotations applied.
- found_out  output  1  1 = match found.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: load data_in and dir into the working register, clear the count, go to SEARCH.
  - SEARCH: each enabled cycle, compare the working register with pattern.
    - Equal: latch found=1, amount=count, aligned=working; go to DONE.
    - Not equal and count==WIDTH-1: latch found=0, amount=0, aligned=captured data_in; go to DONE.
    - Otherwise: rotate the working register by 1 in dir; count++.
  - SEARCH with enable=0: everything holds.
  - DONE: out_valid=1 and outputs stable. On out_valid&&out_ready go to IDLE.
- Rotation wraps: the bit shifted out re-enters at the opposite end. Only match amounts 0..WIDTH-1 are reportable.
- Multiple matches (e.g. pattern 0x55): the smallest k is reported.
- data_in == pattern: found with amount 0.
- in_valid is ignored outside IDLE. No new request is accepted in the same cycle a result is consumed.
- Reset values: state=IDLE, in_ready=1, out_valid=0, aligned_out=0, amount_out=0, found_out=0.
- Reset asserted mid-search or mid-DONE aborts immediately to the reset values. The pending result is discarded.

## Timing
- Accept at edge E0. A match at rotation k raises out_valid after edge E0+k+1 (with enable held high).
  - k=0: out_valid high one cycle after accept.
  - No match: out_valid after edge E0+WIDTH.
- Each enable=0 cycle in SEARCH adds one cycle of latency.
- The DONE→IDLE handshake takes one edge. in_ready is high in the cycle after out_valid&&out_ready. Minimum throughput is one word per k+3 cycles.
- Outputs are registered. No combinational path from inputs to outputs except in_ready and out_valid, which are decoded from state only.

## Structure
- Shared package rotator_pkg holds:
  - functions rol1 and ror1, parametrised by WIDTH;
  - the FSM enum aligner_state_t {IDLE, SEARCH, DONE};
  - the dir encoding constants DIR_LEFT=0 and DIR_RIGHT=1.
- Sub-module: instantiate the existing rotatorunit as the working register:
  - rotatorunit load = accept;
  - rotatorunit enable = accept | (SEARCH && enable && step);
  - rotatorunit dir = captured dir.
- The count, comparator, FSM and result registers live in rotation_aligner.

## Test plan
- Reset then IDLE: in_ready=1, out_valid=0, all outputs 0. Hold in_valid=0 for 5 cycles; no state change.
- pattern=0x12, data_in=0x48, dir=1 → out_valid 3 cycles after accept; found=1, amount=2, aligned=0x12. Repeat with data_in=0x09, dir=0 → amount=1, aligned=0x12.
- pattern=0x12, data_in=0x12 → out_valid one cycle after accept, amount=0. Then pattern=0x12, data_in=0x13 → after 8 cycles found=0, amount=0, aligned=0x13.
- pattern=0x80, data_in=0x01, dir=1, with enable dropped for 4 cycles mid-search → amount=1 (0x01 rotated right once is 0x80), latency extended by exactly 4. Then out_ready=0 for 5 cycles → outputs stable; in_valid is ignored until consumed.
- Assert rst_n=0 during SEARCH (pattern=0x01, data_in=0x80, dir=0) → outputs immediately return to reset values, in_ready=1. A new request after reset completes normally with amount=1.
- Reference-model check over all 256 data_in values with pattern=0xA5, both dir values: amount is the minimal k (or not found), and latency is as specified.
